// File: rtl/serial_frame_transmitter.sv
// rtl/serial_frame_transmitter.sv - FIFO-buffered serial frame transmitter (START, DATA, [PARITY], STOP).
// Optional parity bit between DATA and STOP is enabled by defining SERIAL_TX_PARITY_EN.
module serial_frame_transmitter #(
    parameter int WORD_W    = 64,
    parameter int DEPTH     = 8,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_ready,
    input  logic [WORD_W-1:0]            data_in,
    output logic                         data_out,
    output logic                         serial_clk,
    output logic                         serial_transmit_complete,
    output logic                         busy,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W-1:0]    div_next;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WORD_W-1:0]   shreg;
    logic [WORD_W-1:0]   shifted;
    logic                cur_bit;
    logic                bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic                parity_bit;
`endif

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [WORD_W-1:0]   head;
    logic                pop;
    logic                push;
    logic                drop;

    assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign head       = mem[rd_ptr];

    assign div_next = div_cnt + DIV_W'(1);
    assign bit_end  = (div_cnt == DIV_LAST);

    // A pop happens either from IDLE or on the last cycle of STOP, so back-to-back frames have no gap.
    assign pop  = !rst && !fifo_empty &&
                  ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign push = !rst && data_ready && (!fifo_full || pop);
    assign drop = !rst && data_ready && fifo_full && !pop;

    assign cur_bit = (MSB_FIRST != 0) ? shreg[WORD_W-1] : shreg[0];
    assign shifted = (MSB_FIRST != 0) ? {shreg[WORD_W-2:0], 1'b0}
                                      : {1'b0, shreg[WORD_W-1:1]};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= S_IDLE;
            div_cnt                  <= '0;
            bit_cnt                  <= '0;
            shreg                    <= '0;
            data_out                 <= 1'b0;
            serial_clk               <= 1'b0;
            serial_transmit_complete <= 1'b0;
            busy                     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit               <= 1'b0;
`endif
        end else begin
            serial_transmit_complete <= 1'b0;
            if (state == S_IDLE) begin
                if (pop) begin
                    shreg    <= head;
`ifdef SERIAL_TX_PARITY_EN
                    parity_bit <= ^head;
`endif
                    state    <= S_START;
                    div_cnt  <= '0;
                    data_out <= 1'b1;
                    busy     <= 1'b1;
                end else begin
                    data_out <= 1'b0;
                    busy     <= 1'b0;
                end
                serial_clk <= 1'b0;
            end else if (!bit_end) begin
                div_cnt                  <= div_next;
                serial_clk               <= (div_next >= DIV_HALF);
                serial_transmit_complete <= (state == S_STOP) && (div_next == DIV_LAST);
            end else begin
                div_cnt    <= '0;
                serial_clk <= 1'b0;
                case (state)
                    S_START: begin
                        state    <= S_DATA;
                        bit_cnt  <= '0;
                        data_out <= cur_bit;
                        shreg    <= shifted;
                    end
                    S_DATA: begin
                        if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                            state    <= S_PARITY;
                            data_out <= parity_bit;
`else
                            state    <= S_STOP;
                            data_out <= 1'b0;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            data_out <= cur_bit;
                            shreg    <= shifted;
                        end
                    end
`ifdef SERIAL_TX_PARITY_EN
                    S_PARITY: begin
                        state    <= S_STOP;
                        data_out <= 1'b0;
                    end
`endif
                    S_STOP: begin
                        if (pop) begin
                            shreg    <= head;
`ifdef SERIAL_TX_PARITY_EN
                            parity_bit <= ^head;
`endif
                            state    <= S_START;
                            data_out <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                            data_out <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        data_out <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// tb/tb_serial_frame_transmitter.sv - directed self-checking bench for serial_frame_transmitter.
module tb_serial_frame_transmitter;

    localparam int WORD_W  = 8;
    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 2;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = WORD_W + 3;
`else
    localparam int FRAME_BITS = WORD_W + 2;
`endif
    localparam int FC = FRAME_BITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_ready;
    logic [7:0] data_in;
    logic       data_out, serial_clk, complete, busy, fifo_full, fifo_empty, overflow;
    logic [2:0] fifo_count;

    logic       data_ready_m;
    logic [7:0] data_in_m;
    logic       data_out_m, serial_clk_m, complete_m, busy_m, fifo_full_m, fifo_empty_m, overflow_m;
    logic [2:0] fifo_count_m;

    int checks   = 0;
    int failures = 0;

    logic [7:0] wq [0:7];
    int pc [0:3];
    int pcnt [0:3];
    int povf [0:3];
    int np;

    always #5 clk = ~clk;

    serial_frame_transmitter #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .data_ready(data_ready), .data_in(data_in),
        .data_out(data_out), .serial_clk(serial_clk), .serial_transmit_complete(complete),
        .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    serial_frame_transmitter #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .data_ready(data_ready_m), .data_in(data_in_m),
        .data_out(data_out_m), .serial_clk(serial_clk_m), .serial_transmit_complete(complete_m),
        .busy(busy_m), .fifo_full(fifo_full_m), .fifo_empty(fifo_empty_m),
        .fifo_count(fifo_count_m), .overflow(overflow_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles into a frame (k counts from 0).
    function automatic logic exp_line(input logic [7:0] w, input bit msb, input int k);
        int b;
        b = k / CLK_DIV;
        if (b == 0) return 1'b1;
        if (b <= WORD_W) return msb ? w[WORD_W-b] : w[b-1];
`ifdef SERIAL_TX_PARITY_EN
        if (b == WORD_W + 1) return ^w;
`endif
        return 1'b0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " data_out"}, data_out, 0);
        check({tag, " serial_clk"}, serial_clk, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " complete"}, complete, 0);
    endtask

    // Writes wq[0..nwr-1] on consecutive edges from an idle, empty block and checks nfr frames.
    task automatic play(input int nwr, input int nfr);
        int k;
        int f;
        data_ready = 1'b1;
        data_in    = wq[0];
        tick();
        check("write count", fifo_count, 1);
        check("write busy", busy, 0);
        for (int c = 1; c <= nfr * FC; c++) begin
            if (c < nwr) begin
                data_ready = 1'b1;
                data_in    = wq[c];
            end else begin
                data_ready = 1'b0;
                data_in    = 8'h00;
            end
            tick();
            k = (c - 1) % FC;
            f = (c - 1) / FC;
            check($sformatf("line c=%0d", c), data_out, exp_line(wq[f], 1'b0, k));
            check($sformatf("sclk c=%0d", c), serial_clk, (k % CLK_DIV) >= CLK_DIV / 2);
            check($sformatf("busy c=%0d", c), busy, 1);
            check($sformatf("done c=%0d", c), complete, k == FC - 1);
            for (int p = 0; p < np; p++) begin
                if (pc[p] == c) begin
                    check($sformatf("count c=%0d", c), fifo_count, pcnt[p]);
                    check($sformatf("full c=%0d", c), fifo_full, pcnt[p] == DEPTH);
                    check($sformatf("empty c=%0d", c), fifo_empty, pcnt[p] == 0);
                    check($sformatf("overflow c=%0d", c), overflow, povf[p]);
                end
            end
        end
        data_ready = 1'b0;
        tick();
        check_idle("after frames");
        check("after frames empty", fifo_empty, 1);
    endtask

    initial begin
        rst          = 1'b1;
        data_ready   = 1'b0;
        data_in      = 8'h00;
        data_ready_m = 1'b0;
        data_in_m    = 8'h00;
        np           = 0;
        tick();
        tick();
        check_idle("reset");
        check("reset count", fifo_count, 0);
        check("reset empty", fifo_empty, 1);
        check("reset full", fifo_full, 0);
        check("reset overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // Single 0xA5 frame from idle.
        wq[0] = 8'hA5;
        pc[0] = 1; pcnt[0] = 0; povf[0] = 0;
        np = 1;
        play(1, 1);

        // Three back-to-back words, contiguous frames.
        wq[0] = 8'h01; wq[1] = 8'h02; wq[2] = 8'h03;
        pc[0] = 2;          pcnt[0] = 2; povf[0] = 0;
        pc[1] = FC + 1;     pcnt[1] = 1; povf[1] = 0;
        pc[2] = 2 * FC + 1; pcnt[2] = 0; povf[2] = 0;
        np = 3;
        play(3, 3);

        // Fill to full, then one dropped write.
        wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
        wq[3] = 8'h44; wq[4] = 8'h55; wq[5] = 8'h66;
        pc[0] = 4;          pcnt[0] = 4; povf[0] = 0;
        pc[1] = 5;          pcnt[1] = 4; povf[1] = 1;
        pc[2] = FC + 1;     pcnt[2] = 3; povf[2] = 1;
        pc[3] = 4 * FC + 1; pcnt[3] = 0; povf[3] = 1;
        np = 4;
        play(6, 5);
        check("overflow sticky", overflow, 1);

        // Reset during cycle 7 of a frame, with a queued word and a write attempt under reset.
        data_ready = 1'b1;
        data_in    = 8'h5A;
        tick();
        data_in = 8'h99;
        tick();
        data_ready = 1'b0;
        repeat (6) tick();
        check("pre-reset busy", busy, 1);
        check("pre-reset count", fifo_count, 1);
        rst        = 1'b1;
        data_ready = 1'b1;
        data_in    = 8'hFF;
        tick();
        rst        = 1'b0;
        data_ready = 1'b0;
        check_idle("mid reset");
        check("mid reset count", fifo_count, 0);
        check("mid reset empty", fifo_empty, 1);
        check("mid reset overflow", overflow, 0);
        tick();
        check("post reset busy", busy, 0);
        check("post reset count", fifo_count, 0);
        wq[0] = 8'h3C;
        pc[0] = 1; pcnt[0] = 0; povf[0] = 0;
        np = 1;
        play(1, 1);

        // MSB-first instance sending 0x80.
        data_ready_m = 1'b1;
        data_in_m    = 8'h80;
        tick();
        data_ready_m = 1'b0;
        for (int c = 1; c <= FC; c++) begin
            tick();
            check($sformatf("msb line c=%0d", c), data_out_m, exp_line(8'h80, 1'b1, c - 1));
            check($sformatf("msb done c=%0d", c), complete_m, c == FC);
        end
        tick();
        check("msb idle busy", busy_m, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
